// File: rtl/projection_histogram_if.sv
// projection_histogram_if: hit input, host command and readout signals of projection_histogram.
interface projection_histogram_if;
    logic        hit_valid;
    logic [6:0]  hit_y;
    logic [6:0]  hit_x;
    logic [15:0] command;
    logic [6:0]  read_index;
    logic        start_sending;
    logic [15:0] data_yaxis;
    logic [15:0] data_xaxis;
    logic        running;
    logic [15:0] hits_dropped;
    modport master (
        output hit_valid, hit_y, hit_x, command, read_index,
        input  start_sending, data_yaxis, data_xaxis, running, hits_dropped
    );
    modport slave (
        input  hit_valid, hit_y, hit_x, command, read_index,
        output start_sending, data_yaxis, data_xaxis, running, hits_dropped
    );
endinterface

// File: rtl/projection_histogram.sv
// projection_histogram: 128-bin x/y hit projections, framed and handed to a USB readout stage.
// Define PROJ_HIST_PINGPONG_EN for two banks so acquisition continues during readout.
module projection_histogram #(
    parameter int FRAME_CYCLES = 50000000
) (
    input logic clk,
    input logic reset,
    projection_histogram_if.slave bus
);
    localparam int TW = $clog2(FRAME_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(FRAME_CYCLES - 1);
    typedef enum logic [1:0] {ACQ, ARM, XFER, DONE} state_t;
    state_t state_q, state_d;
    logic [15:0] cmd_q, drop_q, drop_d;
    logic [TW-1:0] timer_q, timer_d;
    logic armed_q, running_q, running_d, start_q;
    logic fire, do_run, do_stop, do_clr, frame_end, hit_ok, hit_drop;

    always_comb begin
        fire = armed_q && bus.command != cmd_q;
        do_run = fire && bus.command == 16'd1;
        do_stop = fire && bus.command == 16'd2;
        do_clr = fire && bus.command == 16'd3;
        frame_end = running_q && !do_clr && timer_q == LAST;
        timer_d = do_clr ? '0 : !running_q ? timer_q : frame_end ? '0 : timer_q + 1'b1;
        running_d = do_run ? 1'b1 : do_stop ? 1'b0 : running_q;
        drop_d = do_clr ? '0 : (hit_drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        state_d = (state_q == ACQ && frame_end) ? ARM :
                  (state_q == ARM && bus.read_index == 7'd127) ? XFER :
                  (state_q == XFER && bus.read_index == 7'd0) ? DONE :
                  (state_q == DONE) ? ACQ : state_q;
    end

    // armed_q masks the first post-reset cycle so a command held through reset never fires
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACQ;
            start_q <= 1'b0;
            cmd_q <= '0;
            armed_q <= 1'b0;
            running_q <= 1'b0;
            timer_q <= '0;
            drop_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= state_d == ARM || state_d == XFER;
            cmd_q <= bus.command;
            armed_q <= 1'b1;
            running_q <= running_d;
            timer_q <= timer_d;
            drop_q <= drop_d;
        end
    end

`ifdef PROJ_HIST_PINGPONG_EN
    logic [15:0] y_q [2][128];
    logic [15:0] x_q [2][128];
    logic sel_q;

    assign hit_ok = bus.hit_valid && running_q && !do_clr;
    assign hit_drop = 1'b0;

    // sel_q names the acquisition bank; the other one is read out
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 128; i++) begin
                    y_q[b][i] <= '0;
                    x_q[b][i] <= '0;
                end
        end else begin
            if (frame_end && state_q == ACQ) begin
                sel_q <= ~sel_q;
                for (int i = 0; i < 128; i++) begin
                    y_q[~sel_q][i] <= '0;
                    x_q[~sel_q][i] <= '0;
                end
            end
            if (do_clr) begin
                for (int i = 0; i < 128; i++) begin
                    y_q[sel_q][i] <= '0;
                    x_q[sel_q][i] <= '0;
                end
            end else if (hit_ok) begin
                if (y_q[sel_q][bus.hit_y] != 16'hFFFF) y_q[sel_q][bus.hit_y] <= y_q[sel_q][bus.hit_y] + 16'd1;
                if (x_q[sel_q][bus.hit_x] != 16'hFFFF) x_q[sel_q][bus.hit_x] <= x_q[sel_q][bus.hit_x] + 16'd1;
            end
        end
    end

    assign bus.data_yaxis = y_q[~sel_q][bus.read_index];
    assign bus.data_xaxis = x_q[~sel_q][bus.read_index];
`else
    logic [15:0] y_q [128];
    logic [15:0] x_q [128];

    assign hit_ok = bus.hit_valid && running_q && !do_clr && state_q == ACQ;
    assign hit_drop = bus.hit_valid && running_q && !do_clr && state_q != ACQ;

    // the shared bank doubles as readout bank, so CLEAR leaves it alone while a transfer is pending
    always_ff @(posedge clk) begin
        if (reset || (do_clr && !start_q) || (state_q == XFER && state_d == DONE)) begin
            for (int i = 0; i < 128; i++) begin
                y_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else if (hit_ok) begin
            if (y_q[bus.hit_y] != 16'hFFFF) y_q[bus.hit_y] <= y_q[bus.hit_y] + 16'd1;
            if (x_q[bus.hit_x] != 16'hFFFF) x_q[bus.hit_x] <= x_q[bus.hit_x] + 16'd1;
        end
    end

    assign bus.data_yaxis = y_q[bus.read_index];
    assign bus.data_xaxis = x_q[bus.read_index];
`endif

    assign bus.start_sending = start_q;
    assign bus.running = running_q;
    assign bus.hits_dropped = drop_q;
endmodule

// File: tb/tb_projection_histogram.sv
// tb_projection_histogram: directed scoreboard bench; a short-frame instance for control flow
// and a long-frame instance running the bin saturation case in parallel.
module tb_projection_histogram;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_sat = 1'b1;
    always #5 clk = ~clk;

    projection_histogram_if bus ();
    projection_histogram_if sbus ();
    projection_histogram #(.FRAME_CYCLES(256)) dut (.clk(clk), .reset(reset), .bus(bus));
    projection_histogram #(.FRAME_CYCLES(70100)) dut_sat (.clk(clk), .reset(rst_sat), .bus(sbus));

`ifdef PROJ_HIST_PINGPONG_EN
    localparam logic [15:0] XFER_DROPS = 16'd0;
    localparam logic [15:0] Y5_AFTER_DONE = 16'd3;
`else
    localparam logic [15:0] XFER_DROPS = 16'd4;
    localparam logic [15:0] Y5_AFTER_DONE = 16'd0;
`endif

    typedef struct {
        int u;
        int k;
        logic [15:0] e;
        string n;
    } exp_t;
    exp_t sb[$];
    exp_t mt;
    logic [15:0] ma;
    int checks = 0;
    int errors = 0;
    bit sat_done = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int u, input int k, input logic [15:0] e, input string n);
        exp_t t;
        t.u = u;
        t.k = k;
        t.e = e;
        t.n = n;
        sb.push_back(t);
    endtask

    function automatic logic [15:0] observe(input int u, input int k);
        if (u == 0)
            return k == 0 ? 16'(bus.start_sending) : k == 1 ? 16'(bus.running) :
                   k == 2 ? bus.data_yaxis : k == 3 ? bus.data_xaxis : bus.hits_dropped;
        return k == 0 ? 16'(sbus.start_sending) : k == 1 ? 16'(sbus.running) :
               k == 2 ? sbus.data_yaxis : k == 3 ? sbus.data_xaxis : sbus.hits_dropped;
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mt = sb.pop_front();
            ma = observe(mt.u, mt.k);
            checks++;
            if (ma !== mt.e) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", mt.n, ma, mt.e);
            end
        end
    end

    task automatic wait_ss(input string n, input int budget);
        int c = 0;
        while (bus.start_sending !== 1'b1 && c < budget) begin
            tick(1);
            c++;
        end
        if (c >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s: start_sending still 0 after %0d cycles, expected 1", n, budget);
        end
    endtask

    initial begin
        bus.hit_valid = 1'b0;
        bus.hit_y = '0;
        bus.hit_x = '0;
        bus.command = 16'd1;
        bus.read_index = '0;
        tick(3);
        reset = 1'b0;
        tick(4);
        expect_out(0, 1, 16'd0, "running_held_cmd_after_reset");
        expect_out(0, 0, 16'd0, "reset_start_sending");
        expect_out(0, 4, 16'd0, "reset_hits_dropped");
        expect_out(0, 2, 16'd0, "reset_data_y");
        expect_out(0, 3, 16'd0, "reset_data_x");
        bus.command = 16'd0;
        tick(1);
        bus.command = 16'd1;
        tick(1);
        expect_out(0, 1, 16'd1, "run_sets_running");
        bus.hit_valid = 1'b1;
        bus.hit_y = 7'd5;
        bus.hit_x = 7'd9;
        tick(3);
        bus.hit_valid = 1'b0;
        wait_ss("frame1_start", 300);
        bus.read_index = 7'd5;
        expect_out(0, 2, 16'd3, "f1_y5");
        expect_out(0, 3, 16'd0, "f1_x5");
        tick(1);
        bus.read_index = 7'd9;
        expect_out(0, 2, 16'd0, "f1_y9");
        expect_out(0, 3, 16'd3, "f1_x9");
        tick(1);
        bus.read_index = 7'd0;
        expect_out(0, 2, 16'd0, "f1_y0");
        expect_out(0, 3, 16'd0, "f1_x0");
        expect_out(0, 0, 16'd1, "arm_start_sending");
        tick(1);
        bus.read_index = 7'd127;
        tick(1);
        expect_out(0, 0, 16'd1, "xfer_start_sending");
        bus.read_index = 7'd64;
        bus.hit_valid = 1'b1;
        bus.hit_y = 7'd10;
        bus.hit_x = 7'd20;
        tick(4);
        bus.hit_valid = 1'b0;
        expect_out(0, 4, XFER_DROPS, "xfer_hits_dropped");
        bus.read_index = 7'd0;
        tick(1);
        expect_out(0, 0, 16'd0, "done_start_sending");
        tick(1);
        expect_out(0, 0, 16'd0, "acq_start_sending_low");
        bus.read_index = 7'd5;
        expect_out(0, 2, Y5_AFTER_DONE, "y5_after_done");
        expect_out(0, 1, 16'd1, "running_after_xfer");
        bus.read_index = 7'd7;
        bus.hit_valid = 1'b1;
        bus.hit_y = 7'd7;
        bus.hit_x = 7'd7;
        tick(2);
        bus.hit_valid = 1'b0;
`ifndef PROJ_HIST_PINGPONG_EN
        expect_out(0, 2, 16'd2, "pre_clear_y7");
        expect_out(0, 3, 16'd2, "pre_clear_x7");
`endif
        tick(1);
        bus.command = 16'd3;
        bus.hit_valid = 1'b1;
        tick(1);
        bus.hit_valid = 1'b0;
        expect_out(0, 4, 16'd0, "clear_hits_dropped");
        expect_out(0, 1, 16'd1, "clear_keeps_running");
`ifndef PROJ_HIST_PINGPONG_EN
        expect_out(0, 2, 16'd0, "clear_y7");
`endif
        tick(1);
        bus.hit_valid = 1'b1;
        tick(1);
        bus.hit_valid = 1'b0;
        tick(8);
        expect_out(0, 1, 16'd1, "held_clear_running");
`ifndef PROJ_HIST_PINGPONG_EN
        expect_out(0, 2, 16'd1, "held_clear_single_y7");
        expect_out(0, 3, 16'd1, "held_clear_single_x7");
`endif
        bus.command = 16'd0;
        tick(1);
        wait_ss("frame2_start", 300);
        expect_out(0, 2, 16'd1, "f2_y7");
        expect_out(0, 3, 16'd1, "f2_x7");
        expect_out(0, 0, 16'd1, "f2_arm");
        tick(1);
        bus.read_index = 7'd127;
        tick(1);
        bus.read_index = 7'd64;
        tick(1);
        expect_out(0, 0, 16'd1, "f2_xfer");
        reset = 1'b1;
        tick(1);
        expect_out(0, 0, 16'd0, "midxfer_reset_start_sending");
        expect_out(0, 1, 16'd0, "midxfer_reset_running");
        expect_out(0, 2, 16'd0, "midxfer_reset_y64");
        expect_out(0, 3, 16'd0, "midxfer_reset_x64");
        tick(1);
        bus.read_index = 7'd7;
        expect_out(0, 2, 16'd0, "post_reset_y7");
        tick(1);
        reset = 1'b0;
        while (!sat_done) tick(1);
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int c;
        sbus.hit_valid = 1'b0;
        sbus.hit_y = '0;
        sbus.hit_x = '0;
        sbus.command = 16'd0;
        sbus.read_index = '0;
        tick(3);
        rst_sat = 1'b0;
        tick(2);
        sbus.command = 16'd1;
        tick(1);
        sbus.hit_valid = 1'b1;
        tick(70000);
        sbus.hit_valid = 1'b0;
        c = 0;
        while (sbus.start_sending !== 1'b1 && c < 300) begin
            tick(1);
            c++;
        end
        if (c >= 300) begin
            checks++;
            errors++;
            $display("FAIL sat_frame_start: start_sending still 0 after 300 cycles, expected 1");
        end
        expect_out(1, 2, 16'hFFFF, "sat_y0");
        expect_out(1, 3, 16'hFFFF, "sat_x0");
        expect_out(1, 4, 16'd0, "sat_hits_dropped");
        tick(1);
        sbus.read_index = 7'd1;
        expect_out(1, 2, 16'd0, "sat_y1");
        tick(1);
        sat_done = 1'b1;
    end
endmodule
